// File: rtl/fft_bitrev_feeder.sv
`default_nettype none
// ============================================================================
// Module  : fft_bitrev_feeder
// Purpose : Ping-pong frame buffer feeding a radix-2 FFT first stage with
//           bit-reversed (a, b) operand pairs.
// Revision: 1.0 - initial release
// ============================================================================
module fft_bitrev_feeder #(
  parameter int LOG2N = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_a,
  output logic [63:0] out_b,
  output logic        out_first,
  output logic        out_last
);

  localparam int               N         = 1 << LOG2N;
  localparam logic [LOG2N-1:0] WCNT_LAST = '1;
  localparam logic [LOG2N-1:0] WCNT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-2:0] RCNT_LAST = '1;
  localparam logic [LOG2N-2:0] RCNT_ONE  = (LOG2N-1)'(1);

  logic [63:0]      mem_q [2][N];
  logic [63:0]      mem_d [2][N];
  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             rbank_q, rbank_d;
  logic [LOG2N-2:0] rcnt_q, rcnt_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_a_q, out_a_d;
  logic [63:0]      out_b_q, out_b_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;

  logic             w_accept;
  logic             w_load;
  logic [LOG2N-1:0] w_idx_a;
  logic [LOG2N-1:0] w_idx_b;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = idx[LOG2N-1-i];
    end
    return r;
  endfunction

  assign in_ready = !full_q[wbank_q];
  assign w_accept = in_valid && in_ready;
  assign w_load   = full_q[rbank_q] && (!out_valid_q || out_ready);
  // Pair k uses natural indices 2k and 2k+1, each bit-reversed.
  assign w_idx_a  = bitrev({rcnt_q, 1'b0});
  assign w_idx_b  = bitrev({rcnt_q, 1'b1});

  always_comb begin
    mem_d       = mem_q;
    full_d      = full_q;
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    rbank_d     = rbank_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    if (w_accept) begin
      mem_d[wbank_q][wcnt_q] = in_data;
      wcnt_d                 = wcnt_q + WCNT_ONE;
      if (wcnt_q == WCNT_LAST) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    // Writer and reader always sit on different banks, so both flag updates coexist.
    if (w_load) begin
      out_a_d     = mem_q[rbank_q][w_idx_a];
      out_b_d     = mem_q[rbank_q][w_idx_b];
      out_first_d = (rcnt_q == '0);
      out_last_d  = (rcnt_q == RCNT_LAST);
      out_valid_d = 1'b1;
      rcnt_d      = rcnt_q + RCNT_ONE;
      if (rcnt_q == RCNT_LAST) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_q       <= '{default: '0};
      full_q      <= '0;
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rbank_q     <= 1'b0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_bitrev_feeder
// Purpose : Scoreboard bench for fft_bitrev_feeder (N = 16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_feeder;

  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;
  localparam int HALF  = N / 2;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        first;
    logic        last;
  } pair_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic        out_first;
  logic        out_last;

  int checks = 0;
  int errors = 0;
  int acc_count = 0;
  int pops = 0;
  int to_send = 0;
  int idx = 0;
  bit pattern = 1'b1;
  bit gaps = 1'b0;
  int rdy_mode = 0;
  int rdy_phase = 0;
  bit acc_evt = 1'b0;
  bit cont_mode = 1'b0;
  int stall_cnt = 0;
  bit held = 1'b0;
  pair_t held_p;

  logic [63:0] frame_q[$];
  pair_t       exp_q[$];

  fft_bitrev_feeder #(.LOG2N(LOG2N)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic int rev(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: observes handshakes that complete at the next rising edge.
  always begin
    @(negedge clk);
    if (clr) begin
      frame_q.delete();
      exp_q.delete();
      held    = 1'b0;
      acc_evt = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!out_valid || out_a !== held_p.a || out_b !== held_p.b ||
            out_first !== held_p.first || out_last !== held_p.last) begin
          errors++;
          $display("FAIL hold_stable: got v=%b a=%h b=%h f=%b l=%b expected v=1 a=%h b=%h f=%b l=%b",
                   out_valid, out_a, out_b, out_first, out_last,
                   held_p.a, held_p.b, held_p.first, held_p.last);
        end
      end
      held = out_valid && !out_ready;
      held_p = '{a: out_a, b: out_b, first: out_first, last: out_last};

      if (cont_mode && in_valid && !in_ready) stall_cnt++;

      if (in_valid && in_ready) begin
        acc_evt = 1'b1;
        acc_count++;
        frame_q.push_back(in_data);
        if (frame_q.size() == N) begin
          for (int k = 0; k < HALF; k++) begin
            pair_t p;
            p.a     = frame_q[rev(2 * k)];
            p.b     = frame_q[rev(2 * k + 1)];
            p.first = (k == 0);
            p.last  = (k == HALF - 1);
            exp_q.push_back(p);
          end
          frame_q.delete();
        end
      end

      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pair_unexpected: got a=%h b=%h expected no pair", out_a, out_b);
        end else begin
          pair_t e;
          e = exp_q.pop_front();
          if (out_a !== e.a || out_b !== e.b || out_first !== e.first || out_last !== e.last) begin
            errors++;
            $display("FAIL pair: got a=%h b=%h f=%b l=%b expected a=%h b=%h f=%b l=%b",
                     out_a, out_b, out_first, out_last, e.a, e.b, e.first, e.last);
          end
        end
      end
    end
  end

  // Input driver: holds each sample until it is accepted.
  always begin
    @(posedge clk);
    #1;
    if (acc_evt) begin
      acc_evt  = 1'b0;
      in_valid = 1'b0;
      if (to_send > 0) to_send--;
    end
    if (!in_valid && to_send > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1;
      in_data  = pattern ? {32'(idx), 32'h0} : {$urandom, $urandom};
      idx++;
    end
  end

  // out_ready generator; mode 0 leaves it to the main sequence.
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: begin
        out_ready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic wait_acc(input int n);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (acc_count >= n) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_acc_timeout: got %0d accepts expected %0d", acc_count, n);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      #1;
      if (to_send == 0 && !in_valid && exp_q.size() == 0 && frame_q.size() == 0 && !out_valid)
        return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending pairs expected 0", exp_q.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_first"}, 64'(out_first), 64'd0);
    check({tag, "_out_last"},  64'(out_last),  64'd0);
    check({tag, "_out_a"},     out_a,          64'd0);
    check({tag, "_out_b"},     out_b,          64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    clr       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;

    // Basic order with latency check
    out_ready = 1'b1; pattern = 1'b1; gaps = 1'b0; idx = 0; acc_count = 0; pops = 0;
    to_send = 16;
    wait_acc(16);
    @(posedge clk); #2;
    check("latency_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #2;
    check("latency_valid", 64'(out_valid), 64'd1);
    check("first_pair_flag", 64'(out_first), 64'd1);
    check("first_pair_a", out_a, {32'd0, 32'd0});
    check("first_pair_b", out_b, {32'd8, 32'd0});
    wait_drain();
    check("basic_pair_count", 64'(pops), 64'd8);

    // Backpressure with 1,0,0 repeating out_ready
    idx = 0; pops = 0; rdy_phase = 0; rdy_mode = 1;
    to_send = 16;
    wait_drain();
    rdy_mode = 0; out_ready = 1'b1;
    check("backpressure_pair_count", 64'(pops), 64'd8);

    // Ping-pong full
    @(posedge clk); #2;
    out_ready = 1'b0; pattern = 1'b0; acc_count = 0;
    to_send = 40;
    wait_acc(32);
    repeat (4) @(posedge clk);
    #2;
    check("pingpong_in_ready_low", 64'(in_ready), 64'd0);
    check("pingpong_accepts", 64'(acc_count), 64'd32);
    check("pingpong_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("pingpong_ready_return_cycle", 64'(i), 64'(HALF - 1));
    to_send += 8;
    wait_drain();

    // Continuous streaming: 4 frames back to back
    cont_mode = 1'b1; stall_cnt = 0; pops = 0;
    to_send = 64;
    wait_drain();
    cont_mode = 1'b0;
    check("continuous_no_stall", 64'(stall_cnt), 64'd0);
    check("continuous_pair_count", 64'(pops), 64'd32);

    // Simultaneous frame completion and bank release
    @(posedge clk); #2;
    out_ready = 1'b0; acc_count = 0;
    to_send = 32;
    wait_acc(16);
    @(posedge clk);
    repeat (9) @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    check("simul_accepts", 64'(acc_count), 64'd32);
    check("simul_in_ready", 64'(in_ready), 64'd1);
    check("simul_last_loaded", 64'(out_last), 64'd1);
    @(posedge clk); #2;
    check("simul_next_first", 64'(out_first && out_valid), 64'd1);
    wait_drain();

    // Randomized traffic with gaps and random backpressure
    gaps = 1'b1; rdy_mode = 2; pops = 0;
    to_send = 80;
    wait_drain();
    rdy_mode = 0; gaps = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    check("random_pair_count", 64'(pops), 64'd40);

    // Reset mid-frame after 9 samples
    pattern = 1'b1; idx = 0; acc_count = 0;
    to_send = 9;
    wait_acc(9);
    @(posedge clk); #2;
    clr = 1'b1; to_send = 0; in_valid = 1'b0;
    #1;
    check_reset_outputs("clr_midframe");
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;

    // Reset during drain of a full frame
    idx = 0; acc_count = 0;
    to_send = 16;
    wait_acc(16);
    repeat (4) @(posedge clk);
    #2;
    check("pre_clr_valid", 64'(out_valid), 64'd1);
    clr = 1'b1;
    #1;
    check_reset_outputs("clr_drain");
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;

    // Fresh frame after reset
    idx = 0; pops = 0;
    to_send = 16;
    wait_drain();
    check("post_clr_pair_count", 64'(pops), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_feeder.md
# fft_bitrev_feeder

Input stage of the radix-2 FFT datapath, directly upstream of the butterfly unit. Accepts a stream of complex samples in natural order into a ping-pong buffer. Emits each completed frame as N/2 pairs in bit-reversed order, so every pair is a first-stage butterfly operand set (a, b). Double buffering lets frame k+1 load while frame k drains.

## Interface
- LOG2N, 4: log2 of frame length N; N = 2^LOG2N, N ≥ 4.
- clk  in  1: clock, rising edge.
- clr  in  1: asynchronous reset, active-high.
- in_valid  in  1: in_data is valid.
- in_ready  out  1: feeder can accept a sample this cycle.
- in_data  in  64: complex sample, {real[63:32], imag[31:0]}, two's complement.
- out_valid  out  1: out_a/out_b hold a valid pair.
- out_ready  in  1: downstream accepts the pair this cycle.
- out_a  out  64: operand a = x[bitrev(2k)].
- out_b  out  64: operand b = x[bitrev(2k+1)].
- out_first  out  1: pair k = 0 of a frame.
- out_last  out  1: pair k = N/2−1 of a frame.

## Operation
- Storage: two banks of N×64 flops, bank0 and bank1. Each bank has a full flag.
- Write side state: wbank (1 bit) and wcnt (LOG2N bits).
- in_ready = !full[wbank]. Combinational; depends only on registered state.
- Accept condition: in_valid && in_ready.
  - On accept: mem[wbank][wcnt] ← in_data, then wcnt++.
  - If wcnt was N−1: set full[wbank], toggle wbank, wcnt ← 0.
- Read side state: rbank (1 bit) and rcnt (LOG2N−1 bits), plus the output register stage (out_valid, out_a, out_b, out_first, out_last).
- Load condition: full[rbank] && (!out_valid || out_ready).
  - On load: out_a ← mem[rbank][bitrev(2·rcnt)], out_b ← mem[rbank][bitrev(2·rcnt+1)].
  - Also on load: out_first ← (rcnt==0), out_last ← (rcnt==N/2−1), out_valid ← 1, rcnt++.
  - If rcnt was N/2−1: clear full[rbank], toggle rbank, rcnt ← 0.
  - If not loading and out_ready is high: out_valid ← 0.
- bitrev() reverses the LOG2N-bit index.
- Data is passed bit-exact. No arithmetic or width change.
- Out of scope: twiddle selection. Stage-1 twiddle is 1; the downstream controller supplies it.
- Simultaneous events:
  - A write that completes one bank and a read that frees the other bank in the same cycle both take effect.
  - The writer and reader never address the same bank at the same time. Writing requires !full, reading requires full.
- Both banks full: in_ready = 0 until the reader frees a bank.
- out_valid is held with stable data while out_ready = 0 (no drop, no change).
- Reset (clr high, any time including mid-frame):
  - full flags, wbank, wcnt, rbank, rcnt ← 0.
  - out_valid, out_first, out_last ← 0; out_a, out_b ← 0; memory contents ← 0.
  - Any partial frame is discarded.
  - While clr is asserted, in_ready = 1 (bank0 empty), but no write occurs.

## Timing
- Sample acceptance: one per cycle at full rate.
- Latency: when the frame's last sample is accepted at edge T, the first pair is registered at edge T+1. out_valid is high in the cycle after T+1.
- Drain: with out_ready held high, the N/2 pairs appear on N/2 consecutive cycles.
- Throughput: the drain rate (N/2 cycles per frame) exceeds the fill rate (N cycles per frame). Continuous input therefore never deasserts in_ready while out_ready is held high.
- Reset values: in_ready = 1; out_valid = out_first = out_last = 0; out_a = out_b = 64'h0.

## Test plan
- Basic order (N=16): feed in_data = {k, 32'h0} for k = 0..15 on 16 consecutive cycles with out_ready=1.
  - Required real parts of (a, b): (0,8), (4,12), (2,10), (6,14), (1,9), (5,13), (3,11), (7,15).
  - out_first on the first pair, out_last on the eighth.
  - First out_valid occurs 1 cycle after the 16th accept.
- Backpressure: same stimulus, out_ready toggling 1,0,0,1,… → each pair is held stable while stalled. No pair is lost or duplicated; the sequence is identical to the basic-order case.
- Ping-pong full: out_ready=0; stream 40 samples.
  - in_ready falls after the 32nd accept; samples 33..40 wait.
  - Raise out_ready: frame 0 drains, then frame 1 drains. in_ready returns to 1 after frame 0's last pair loads.
- Continuous streaming: 4 back-to-back frames, in_valid=1, out_ready=1 → in_ready never drops. Output frames appear in input order with correct bit-reversed pairs.
- Reset mid-operation: assert clr after 9 samples of frame 0 and again during the drain of a full frame.
  - All outputs return to reset values immediately (asynchronous).
  - A fresh 16-sample frame afterward produces exactly the basic-order sequence.
- Simultaneous boundary: time frame 1's 16th accept on the same edge as frame 0's last pair load → full[1] is set and full[0] is cleared on that edge. in_ready stays 1, and frame 1's first pair loads on the next edge.
